// File: rtl/cdr_pkg.sv
// Shared CDR loop definitions: FSM state and step-direction encodings.
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Width of a down-counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_ptr.sv
// Modulo-NPHASE up/down phase pointer with registered output; inc wins over dec.
module phase_ptr #(
  parameter int unsigned NPHASE = 8,
  parameter int unsigned PW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [PW-1:0] ptr_o
);

  localparam logic [PW-1:0] LAST = PW'(NPHASE - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end else if (dec_i) begin
      ptr_d = (ptr_q == '0) ? LAST : ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/phase_step_ctrl.sv
// CDR loop controller: steps the sampling phase on filter decisions, blanks the
// filter for a hold-off window after each step, and tracks lock.
module phase_step_ctrl
  import cdr_pkg::*;
#(
  parameter int unsigned NPHASE   = 8,
  parameter int unsigned PW       = 3,
  parameter int unsigned HOLDOFF  = 4,
  parameter int unsigned LOCK_CNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          dn,
  output logic [PW-1:0] phase_sel,
  output logic          filt_clr,
  output logic          step_up,
  output logic          step_dn,
  output logic          locked
);

  localparam int unsigned HW = cnt_width(HOLDOFF);
  localparam int unsigned QW = $clog2(LOCK_CNT + 1);

  state_e        state_q;
  dir_e          last_dir_q;
  logic [HW-1:0] hold_q;
  logic [QW-1:0] quiet_q;
  logic          filt_clr_q;
  logic          step_up_q;
  logic          step_dn_q;
  logic          locked_q;
  logic          inc_c;
  logic          dec_c;

  // A single clean decision in TRACK moves the pointer on the same edge.
  assign inc_c = en && (state_q == ST_TRACK) && up && !dn;
  assign dec_c = en && (state_q == ST_TRACK) && dn && !up;

  phase_ptr #(
    .NPHASE (NPHASE),
    .PW     (PW)
  ) u_phase_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (inc_c),
    .dec_i (dec_c),
    .ptr_o (phase_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_NONE;
      hold_q     <= '0;
      quiet_q    <= '0;
      filt_clr_q <= 1'b0;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      filt_clr_q <= 1'b0;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      if (!en) begin
        state_q    <= ST_IDLE;
        last_dir_q <= DIR_NONE;
        hold_q     <= '0;
        quiet_q    <= '0;
        locked_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q    <= ST_TRACK;
            filt_clr_q <= 1'b1;
          end
          ST_TRACK: begin
            if (inc_c || dec_c) begin
              // Repeated steps in one direction mean drift, not dither.
              if ((inc_c && last_dir_q == DIR_UP) || (dec_c && last_dir_q == DIR_DN)) begin
                locked_q <= 1'b0;
              end
              last_dir_q <= inc_c ? DIR_UP : DIR_DN;
              step_up_q  <= inc_c;
              step_dn_q  <= dec_c;
              filt_clr_q <= 1'b1;
              state_q    <= ST_HOLD;
              hold_q     <= HW'(HOLDOFF - 1);
              quiet_q    <= '0;
            end else if (up && dn) begin
              quiet_q <= '0;
            end else if (quiet_q != QW'(LOCK_CNT)) begin
              quiet_q <= quiet_q + QW'(1);
              if (quiet_q == QW'(LOCK_CNT - 1)) begin
                locked_q <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (hold_q == '0) begin
              state_q <= ST_TRACK;
            end else begin
              hold_q <= hold_q - HW'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign filt_clr = filt_clr_q;
  assign step_up  = step_up_q;
  assign step_dn  = step_dn_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_phase_step_ctrl.sv
// Self-checking bench for phase_step_ctrl: time-based behavioural model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_phase_step_ctrl;

  localparam int NPHASE   = 8;
  localparam int PW       = 3;
  localparam int HOLDOFF  = 4;
  localparam int LOCK_CNT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic          up  = 1'b0;
  logic          dn  = 1'b0;
  logic [PW-1:0] phase_sel;
  logic          filt_clr;
  logic          step_up;
  logic          step_dn;
  logic          locked;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model state: the loop samples decisions only at edges >= m_track_from.
  int m_edge       = 0;
  int m_track_from = 0;
  int m_phase      = 0;
  int m_quiet      = 0;
  int m_last       = 0;
  bit m_active     = 1'b0;
  bit m_filt       = 1'b0;
  bit m_up         = 1'b0;
  bit m_dn         = 1'b0;
  bit m_locked     = 1'b0;

  phase_step_ctrl #(
    .NPHASE   (NPHASE),
    .PW       (PW),
    .HOLDOFF  (HOLDOFF),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .dn        (dn),
    .phase_sel (phase_sel),
    .filt_clr  (filt_clr),
    .step_up   (step_up),
    .step_dn   (step_dn),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edge = 0; m_track_from = 0; m_phase = 0; m_quiet = 0; m_last = 0;
    m_active = 1'b0; m_filt = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit u, input bit d);
    int dir;
    m_filt = 1'b0; m_up = 1'b0; m_dn = 1'b0;
    if (!e) begin
      m_active = 1'b0; m_quiet = 0; m_locked = 1'b0; m_last = 0;
    end else if (!m_active) begin
      m_active = 1'b1; m_filt = 1'b1; m_track_from = m_edge + 1;
    end else if (m_edge >= m_track_from) begin
      if (u != d) begin
        dir = u ? 1 : 2;
        m_phase = u ? (m_phase + 1) % NPHASE : (m_phase + NPHASE - 1) % NPHASE;
        m_filt = 1'b1; m_up = u; m_dn = d;
        if (m_last == dir) m_locked = 1'b0;
        m_last = dir;
        m_quiet = 0;
        m_track_from = m_edge + HOLDOFF + 1;
      end else if (u) begin
        m_quiet = 0;
      end else begin
        if (m_quiet < LOCK_CNT) m_quiet++;
        if (m_quiet == LOCK_CNT) m_locked = 1'b1;
      end
    end
    m_edge++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(en, up, dn);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("cyc phase_sel", int'(phase_sel), m_phase);
        chk("cyc filt_clr", int'(filt_clr), int'(m_filt));
        chk("cyc step_up", int'(step_up), int'(m_up));
        chk("cyc step_dn", int'(step_dn), int'(m_dn));
        chk("cyc locked", int'(locked), int'(m_locked));
      end
    end
  end

  task automatic cyc(input bit e, input bit u, input bit d);
    en = e; up = u; dn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input bit u, input bit d);
    cyc(1'b1, u, d);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    chk("rst phase_sel", int'(phase_sel), 0);
    chk("rst locked", int'(locked), 0);
    chk("rst filt_clr", int'(filt_clr), 0);

    cyc(1'b1, 1'b0, 1'b0);
    chk("enable filt_clr", int'(filt_clr), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("enable filt_clr drop", int'(filt_clr), 0);

    repeat (7) do_step(1'b1, 1'b0);
    chk("preload phase", int'(phase_sel), 7);
    cyc(1'b1, 1'b1, 1'b0);
    chk("wrap up phase", int'(phase_sel), 0);
    chk("wrap up step_up", int'(step_up), 1);
    chk("wrap up filt_clr", int'(filt_clr), 1);
    for (int i = 0; i < HOLDOFF; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk("hold blanks up", int'(step_up), 0);
    end
    cyc(1'b1, 1'b1, 1'b0);
    chk("step after hold", int'(step_up), 1);
    chk("step after hold phase", int'(phase_sel), 1);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);

    do_step(1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("wrap dn phase", int'(phase_sel), 7);
    chk("wrap dn step_dn", int'(step_dn), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("wrap dn pulse one cycle", int'(step_dn), 0);
    repeat (HOLDOFF - 1) cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b1, 1'b1);
    chk("illegal no step phase", int'(phase_sel), 7);
    chk("illegal quiet model", m_quiet, 0);

    for (int i = 1; i <= LOCK_CNT; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == LOCK_CNT - 1) chk("lock early", int'(locked), 0);
      if (i == LOCK_CNT) chk("lock reached", int'(locked), 1);
    end
    cyc(1'b1, 1'b1, 1'b0);
    chk("dither up keeps lock", int'(locked), 1);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("dither dn keeps lock", int'(locked), 1);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("first up keeps lock", int'(locked), 1);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("run clears lock", int'(locked), 0);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);

    repeat (LOCK_CNT) cyc(1'b1, 1'b0, 1'b0);
    chk("relock", int'(locked), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("relock dither", int'(locked), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("disable locked", int'(locked), 0);
    chk("disable phase kept", int'(phase_sel), 0);
    chk("disable no filt_clr", int'(filt_clr), 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("disable beats up", int'(step_up), 0);
    chk("disable beats up phase", int'(phase_sel), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("reenable filt_clr", int'(filt_clr), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("reenable tracks", int'(step_up), 1);
    chk("reenable phase", int'(phase_sel), 1);
    repeat (HOLDOFF) cyc(1'b1, 1'b0, 1'b0);

    repeat (3) do_step(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pre reset phase", int'(phase_sel), 5);
    #2 rst = 1'b1;
    #1;
    chk("async rst phase", int'(phase_sel), 0);
    chk("async rst filt_clr", int'(filt_clr), 0);
    chk("async rst steps", int'(step_up) + int'(step_dn), 0);
    chk("async rst locked", int'(locked), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0);
    chk("post reset idle", int'(filt_clr), 1);
    chk("post reset no step", int'(step_up), 0);

    for (int b = 0; b < 60; b++) begin
      int pct;
      case ($urandom_range(0, 3))
        0: pct = 1;
        1: pct = 8;
        2: pct = 25;
        default: pct = 50;
      endcase
      for (int i = 0; i < 50; i++) begin
        int r;
        r = $urandom_range(0, 299);
        if (r == 0) begin
          #2 rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
        end else begin
          cyc(r > 4, $urandom_range(0, 99) < pct, $urandom_range(0, 99) < pct);
        end
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
